// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: walks the columns, debounces whole-scan results,
// pulses once per accepted key and shifts each accepted digit into a 16-bit value.
module keypad_scanner #(
   parameter int SCAN_TICKS     = 5000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  row_n,
   input  logic        clear,
   output logic [3:0]  col_n,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic        key_down,
   output logic [15:0] value
);

   localparam int DW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DEBOUNCE,
      S_PRESSED,
      S_RELEASE
   } state_t;

   function automatic logic [2:0] count_hits(input logic [3:0] v);
      count_hits = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

   function automatic logic [1:0] first_row(input logic [3:0] v);
      first_row = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (v[i]) first_row = 2'(i);
      end
   endfunction

   logic [DW-1:0] dwell_q, dwell_d;
   logic [1:0]    col_idx_q, col_idx_d;
   logic [3:0]    row_s1_q, row_s2_q;
   logic [1:0]    acc_cnt_q, acc_cnt_d;
   logic [3:0]    acc_key_q, acc_key_d;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    cand_q, cand_d;
   logic          key_valid_q, key_valid_d;
   logic [3:0]    key_code_q, key_code_d;
   logic          key_down_q, key_down_d;
   logic [15:0]   value_q, value_d;

   logic          sample, scan_done;
   logic [3:0]    rows_low;
   logic [2:0]    hits, hit_sum;
   logic [1:0]    base_cnt, scan_cnt;
   logic [3:0]    scan_key;
   logic          res_none, res_key, accept;
   logic [3:0]    accept_code;

   // Column scan and per-scan accumulation of low rows. The result for the
   // scan is formed combinationally on the column-3 sample so the FSM can act
   // on that same edge.
   always_comb begin
      sample    = (dwell_q == DW'(SCAN_TICKS - 1));
      scan_done = sample && (col_idx_q == 2'd3);
      dwell_d   = sample ? '0 : dwell_q + DW'(1);
      col_idx_d = sample ? col_idx_q + 2'd1 : col_idx_q;

      rows_low = ~row_s2_q;
      hits     = count_hits(rows_low);
      base_cnt = (col_idx_q == 2'd0) ? 2'd0 : acc_cnt_q;
      hit_sum  = {1'b0, base_cnt} + hits;
      scan_cnt = (hit_sum > 3'd2) ? 2'd2 : hit_sum[1:0];
      if (hits == 3'd1) begin
         scan_key = {first_row(rows_low), col_idx_q};
      end else if (col_idx_q == 2'd0) begin
         scan_key = 4'h0;
      end else begin
         scan_key = acc_key_q;
      end

      acc_cnt_d = sample ? scan_cnt : acc_cnt_q;
      acc_key_d = sample ? scan_key : acc_key_q;
      res_none  = (scan_cnt == 2'd0);
      res_key   = (scan_cnt == 2'd1);
   end

   // MULTI falls through as "not a key" everywhere except PRESSED/RELEASE,
   // where any activity keeps the key held.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cand_d      = cand_q;
      key_valid_d = 1'b0;
      key_code_d  = key_code_q;
      key_down_d  = key_down_q;
      value_d     = clear ? 16'h0000 : value_q;
      accept      = 1'b0;
      accept_code = cand_q;

      if (scan_done) begin
         unique case (state_q)
            S_IDLE: begin
               if (res_key) begin
                  if (DEBOUNCE_SCANS <= 1) begin
                     accept      = 1'b1;
                     accept_code = scan_key;
                  end else begin
                     state_d = S_DEBOUNCE;
                     cand_d  = scan_key;
                     cnt_d   = CW'(1);
                  end
               end
            end
            S_DEBOUNCE: begin
               if (res_key && scan_key == cand_q) begin
                  if (int'(cnt_q) + 1 >= DEBOUNCE_SCANS) begin
                     accept      = 1'b1;
                     accept_code = cand_q;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end else if (res_key) begin
                  cand_d = scan_key;
                  cnt_d  = CW'(1);
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_PRESSED: begin
               if (res_none) begin
                  if (DEBOUNCE_SCANS <= 1) begin
                     state_d    = S_IDLE;
                     key_down_d = 1'b0;
                  end else begin
                     state_d = S_RELEASE;
                     cnt_d   = CW'(1);
                  end
               end
            end
            S_RELEASE: begin
               if (res_none) begin
                  if (int'(cnt_q) + 1 >= DEBOUNCE_SCANS) begin
                     state_d    = S_IDLE;
                     key_down_d = 1'b0;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end else begin
                  state_d = S_PRESSED;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      if (accept) begin
         state_d     = S_PRESSED;
         cand_d      = accept_code;
         key_valid_d = 1'b1;
         key_code_d  = accept_code;
         key_down_d  = 1'b1;
         if (!clear) value_d = {value_q[11:0], accept_code};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dwell_q     <= '0;
         col_idx_q   <= 2'd0;
         row_s1_q    <= 4'hF;
         row_s2_q    <= 4'hF;
         acc_cnt_q   <= 2'd0;
         acc_key_q   <= 4'h0;
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         cand_q      <= 4'h0;
         key_valid_q <= 1'b0;
         key_code_q  <= 4'h0;
         key_down_q  <= 1'b0;
         value_q     <= 16'h0000;
      end else begin
         dwell_q     <= dwell_d;
         col_idx_q   <= col_idx_d;
         row_s1_q    <= row_n;
         row_s2_q    <= row_s1_q;
         acc_cnt_q   <= acc_cnt_d;
         acc_key_q   <= acc_key_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cand_q      <= cand_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
         key_down_q  <= key_down_d;
         value_q     <= value_d;
      end
   end

   assign col_n     = ~(4'b0001 << col_idx_q);
   assign key_valid = key_valid_q;
   assign key_code  = key_code_q;
   assign key_down  = key_down_q;
   assign value     = value_q;

endmodule
